sha256_msg_ctrl: RTL and testbench

SHA256_MSG_CTRL -- requirements
Module: sha256_msg_ctrl

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/sha256_Hash_in.sv | 15 +
 rtl/sha256_msg_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sha256_msg_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-controller definitions: FSM encoding, buffer slot
// constants, the initial hash value and tail-word padding helpers.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } msg_state_e;

    localparam int unsigned   BLOCK_WORDS = 16;
    localparam logic [3:0]    SLOT_LEN_HI = 4'd14;
    localparam logic [3:0]    SLOT_LEN_LO = 4'd15;
    localparam logic [3:0]    SLOT_LAST   = 4'd15;
    localparam logic [31:0]   PAD_WORD    = 32'h8000_0000;

    localparam logic [31:0] SHA256_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Non-last words always carry 4 bytes; out-of-range counts saturate at 4.
    function automatic logic [2:0] tail_bytes(input logic last, input logic [2:0] nbytes);
        if (!last || nbytes > 3'd4) begin
            return 3'd4;
        end
        return nbytes;
    endfunction

    // Keeps the first n bytes, puts the 0x80 marker right after them.
    function automatic logic [31:0] pad_tail(input logic [31:0] data, input logic [2:0] n);
        case (n)
            3'd0:    return PAD_WORD;
            3'd1:    return {data[31:24], 8'h80, 16'h0000};
            3'd2:    return {data[31:16], 8'h80, 8'h00};
            3'd3:    return {data[31:8], 8'h80};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/sha256_Hash_in.sv
// Source of the SHA-256 initial chaining value H0..H7, word 0 in the top bits.
module sha256_Hash_in
    import sha256_pkg::*;
(
    output logic [255:0] hash_in
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_iv
            assign hash_in[255-32*gi -: 32] = SHA256_IV[gi];
        end
    endgenerate

endmodule

// File: rtl/sha256_msg_ctrl.sv
// Streams 32-bit message words into 512-bit padded blocks, launches the
// external sha256_core per block and publishes the final digest.
module sha256_msg_ctrl
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    input  logic [31:0]  msg_data,
    input  logic         msg_last,
    input  logic [2:0]   msg_bytes,
    output logic         msg_ready,
    output logic [511:0] core_data_in,
    output logic [255:0] core_hash_in,
    output logic         core_input_valid,
    input  logic [255:0] core_hash_out,
    input  logic         core_output_valid,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    logic [255:0] iv;
    msg_state_e   state_q;
    logic [31:0]  buf_q [BLOCK_WORDS];
    logic [3:0]   wcnt_q;
    logic [63:0]  bitlen_q;
    logic [255:0] chain_q;
    logic [255:0] digest_q;
    logic         placed_q;
    logic         final_q;
    logic         more_pad_q;
    logic         more_data_q;
    logic         civ_q;
    logic         dv_q;

    logic         accept;
    logic [3:0]   in_slot;
    logic [2:0]   in_bytes;
    logic [31:0]  in_word;
    logic [63:0]  in_bitlen;

    sha256_Hash_in u_hash_in (
        .hash_in (iv)
    );

    // The first word of a message behaves as a LOAD from a fresh context.
    always_comb begin
        accept    = msg_valid && msg_ready;
        in_slot   = (state_q == ST_IDLE) ? 4'd0 : wcnt_q;
        in_bytes  = tail_bytes(msg_last, msg_bytes);
        in_word   = msg_last ? pad_tail(msg_data, in_bytes) : msg_data;
        in_bitlen = ((state_q == ST_IDLE) ? 64'd0 : bitlen_q) + {58'd0, in_bytes, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            bitlen_q    <= 64'd0;
            chain_q     <= iv;
            digest_q    <= 256'd0;
            placed_q    <= 1'b0;
            final_q     <= 1'b0;
            more_pad_q  <= 1'b0;
            more_data_q <= 1'b0;
            civ_q       <= 1'b0;
            dv_q        <= 1'b0;
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else begin
            civ_q <= 1'b0;
            dv_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        if (state_q == ST_IDLE) begin
                            chain_q     <= iv;
                            placed_q    <= 1'b0;
                            final_q     <= 1'b0;
                            more_pad_q  <= 1'b0;
                            more_data_q <= 1'b0;
                        end
                        buf_q[in_slot] <= in_word;
                        bitlen_q       <= in_bitlen;
                        wcnt_q         <= in_slot + 4'd1;
                        if (msg_last) begin
                            placed_q <= (in_bytes != 3'd4);
                        end
                        // A full block launches at once; a last word here leaves only padding.
                        if (in_slot == SLOT_LAST) begin
                            state_q     <= ST_LAUNCH;
                            civ_q       <= 1'b1;
                            more_data_q <= !msg_last;
                            more_pad_q  <= msg_last;
                        end else begin
                            state_q <= msg_last ? ST_PAD : ST_LOAD;
                        end
                    end
                end
                ST_PAD: begin
                    if (wcnt_q == SLOT_LEN_HI && placed_q) begin
                        buf_q[SLOT_LEN_HI] <= bitlen_q[63:32];
                        buf_q[SLOT_LEN_LO] <= bitlen_q[31:0];
                        final_q            <= 1'b1;
                        civ_q              <= 1'b1;
                        state_q            <= ST_LAUNCH;
                    end else begin
                        buf_q[wcnt_q] <= placed_q ? 32'd0 : PAD_WORD;
                        placed_q      <= 1'b1;
                        wcnt_q        <= wcnt_q + 4'd1;
                        if (wcnt_q == SLOT_LAST) begin
                            more_pad_q <= 1'b1;
                            civ_q      <= 1'b1;
                            state_q    <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_output_valid) begin
                        chain_q     <= core_hash_out;
                        wcnt_q      <= 4'd0;
                        more_pad_q  <= 1'b0;
                        more_data_q <= 1'b0;
                        if (final_q) begin
                            state_q <= ST_DONE;
                        end else if (more_pad_q) begin
                            state_q <= ST_PAD;
                        end else if (more_data_q) begin
                            state_q <= ST_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    digest_q <= chain_q;
                    dv_q     <= 1'b1;
                    final_q  <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_block
            assign core_data_in[511-32*gi -: 32] = buf_q[gi];
        end
    endgenerate

    assign core_hash_in     = chain_q;
    assign core_input_valid = civ_q;
    assign digest           = digest_q;
    assign digest_valid     = dv_q;
    assign msg_ready        = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: a behavioural sha256_core with random latency,
// byte-level padding model and reference digests.
`timescale 1ns/1ps
module tb_sha256_msg_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         msg_valid = 1'b0;
    logic [31:0]  msg_data = 32'd0;
    logic         msg_last = 1'b0;
    logic [2:0]   msg_bytes = 3'd0;
    logic         msg_ready;
    logic [511:0] core_data_in;
    logic [255:0] core_hash_in;
    logic         core_input_valid;
    logic [255:0] core_hash_out = 256'd0;
    logic         core_output_valid = 1'b0;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;

    always #5 clk = ~clk;

    sha256_msg_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .msg_valid         (msg_valid),
        .msg_data          (msg_data),
        .msg_last          (msg_last),
        .msg_bytes         (msg_bytes),
        .msg_ready         (msg_ready),
        .core_data_in      (core_data_in),
        .core_hash_in      (core_hash_in),
        .core_input_valid  (core_input_valid),
        .core_hash_out     (core_hash_out),
        .core_output_valid (core_output_valid),
        .digest            (digest),
        .digest_valid      (digest_valid),
        .busy              (busy)
    );

    localparam logic [255:0] IV_TB =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    byte unsigned msg_q[$];
    logic [511:0] exp_blk_q[$];
    logic [255:0] exp_chain = IV_TB;
    logic [255:0] model_digest;
    logic [255:0] last_digest = 256'd0;
    int launches = 0;
    int min_lat = 1;
    bit stub_busy = 1'b0;
    int neg_cnt = 0;
    int cov_neg = 0;
    int dv_neg = 0;
    int dv_count = 0;

    // Standard byte-level SHA-256 padding, then fold the blocks for the digest.
    task automatic build_model();
        byte unsigned p[$];
        logic [63:0]  len;
        logic [511:0] blk;
        logic [255:0] h;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        len = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        exp_blk_q.delete();
        h = IV_TB;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
            exp_blk_q.push_back(blk);
            h = sha_compress(h, blk);
        end
        model_digest = h;
    endtask

    // Behavioural sha256_core.
    initial begin : stub_core
        logic [511:0] blk;
        logic [255:0] hin;
        logic [255:0] res;
        int lat;
        forever begin
            @(posedge clk);
            #1;
            if (core_input_valid) begin
                stub_busy = 1'b1;
                launches++;
                blk = core_data_in;
                hin = core_hash_in;
                check_val("core_hash_in", hin, exp_chain);
                if (exp_blk_q.size() > 0) check_val("core_data_in", blk, exp_blk_q.pop_front());
                else check_val("launch_unexpected", 512'(exp_blk_q.size()), 512'd1);
                lat = $urandom_range(20, min_lat);
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    #1;
                    if (k == 0) check_val("civ_one_cycle", core_input_valid, 1'b0);
                end
                res = sha_compress(hin, blk);
                core_hash_out = res;
                core_output_valid = 1'b1;
                exp_chain = res;
                @(posedge clk);
                #1;
                core_output_valid = 1'b0;
                stub_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (core_output_valid) cov_neg = neg_cnt;
            if (digest_valid) begin
                dv_count++;
                dv_neg = neg_cnt;
                last_digest = digest;
            end
            neg_cnt++;
        end
    end

    task automatic send_msg(input bit gaps);
        int n, nw, nb, to;
        logic [31:0] d;
        n  = msg_q.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? n - 4 * w : 4;
            for (int k = 0; k < 4; k++) begin
                if (k < nb) d[31-8*k -: 8] = msg_q[4*w+k];
                else d[31-8*k -: 8] = gaps ? 8'hA5 : 8'h00;
            end
            if (gaps) begin
                msg_valid = 1'b0;
                repeat ($urandom_range(3, 0)) @(negedge clk);
            end
            msg_valid = 1'b1;
            msg_data  = d;
            msg_last  = (w == nw - 1);
            msg_bytes = (w == nw - 1) ? 3'(nb) : 3'(w);
            to = 0;
            while (!msg_ready && to < 200) begin
                @(negedge clk);
                to++;
            end
            if (to >= 200) check_val("ready_timeout", 512'(to), 512'd0);
            @(negedge clk);
        end
        // Keep offering junk: it must not be consumed while the block is finished.
        msg_data  = 32'hDEADBEEF;
        msg_last  = 1'b1;
        msg_bytes = 3'd2;
        check_val("ready_low_after_last", msg_ready, 1'b0);
        repeat (3) @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic run_msg(input string tag, input bit gaps, input bit has_ref, input logic [255:0] ref_digest);
        int dv0, nblk, to;
        build_model();
        nblk = exp_blk_q.size();
        exp_chain = IV_TB;
        launches = 0;
        dv0 = dv_count;
        send_msg(gaps);
        to = 0;
        while (dv_count == dv0 && to < 3000) begin
            @(negedge clk);
            to++;
        end
        check_val({tag, "_digest_seen"}, 512'(to < 3000), 512'd1);
        check_val({tag, "_digest_model"}, last_digest, model_digest);
        if (has_ref) check_val({tag, "_digest_ref"}, last_digest, ref_digest);
        check_val({tag, "_launches"}, 512'(launches), 512'(nblk));
        check_val({tag, "_dv_latency"}, 512'(dv_neg - cov_neg), 512'd2);
        repeat (5) @(negedge clk);
        check_val({tag, "_dv_once"}, 512'(dv_count - dv0), 512'd1);
        check_val({tag, "_digest_hold"}, digest, model_digest);
        check_val({tag, "_idle"}, busy, 1'b0);
        $display("msg %s: bytes=%0d blocks=%0d launches=%0d digest=%h",
                 tag, msg_q.size(), nblk, launches, last_digest);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        string s56;
        int lens[4];
        int dv0, to;
        lens = '{55, 60, 100, 130};
        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("rst_msg_ready", msg_ready, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_civ", core_input_valid, 1'b0);
        check_val("rst_dv", digest_valid, 1'b0);
        check_val("rst_digest", digest, 256'd0);
        check_val("rst_chain_iv", core_hash_in, IV_TB);
        $display("reset: ready=%0b busy=%0b hash_in=%h", msg_ready, busy, core_hash_in);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", 1'b0, 1'b1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        msg_q.delete();
        run_msg("empty", 1'b0, 1'b1, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        msg_q.delete();
        for (int i = 0; i < s56.len(); i++) msg_q.push_back(s56[i]);
        run_msg("abc56", 1'b0, 1'b1, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'($urandom_range(255, 0)));
        run_msg("rand64_gaps", 1'b1, 1'b0, 256'd0);

        foreach (lens[li]) begin
            msg_q.delete();
            for (int i = 0; i < lens[li]; i++) msg_q.push_back(8'(i * 7 + 3));
            run_msg($sformatf("len%0d", lens[li]), 1'b1, 1'b0, 256'd0);
        end

        // Reset while the core is busy; its late result must be ignored.
        msg_q = '{8'h61, 8'h62, 8'h63};
        build_model();
        exp_chain = IV_TB;
        min_lat = 8;
        dv0 = dv_count;
        send_msg(1'b0);
        to = 0;
        while (!stub_busy && to < 200) begin
            @(negedge clk);
            to++;
        end
        check_val("rst_wait_launch_seen", stub_busy, 1'b1);
        repeat (2) @(negedge clk);
        check_val("rst_wait_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_wait_ready", msg_ready, 1'b1);
        check_val("rst_wait_busy", busy, 1'b0);
        to = 0;
        while (stub_busy && to < 100) begin
            @(negedge clk);
            to++;
        end
        repeat (4) @(negedge clk);
        check_val("rst_wait_no_dv", 512'(dv_count - dv0), 512'd0);
        check_val("rst_wait_still_idle", busy, 1'b0);
        check_val("rst_wait_chain_iv", core_hash_in, IV_TB);
        $display("reset in WAIT: busy=%0b digest_valid_count=%0d", busy, dv_count - dv0);
        min_lat = 1;

        run_msg("abc_after_reset", 1'b0, 1'b1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
